sev_seg_scan_ctrl: RTL and testbench

//   Multiplexed N-digit seven-segment display controller.
//   - Accepts an unsigned binary value on a load strobe.
//   - Converts it to BCD sequentially (shift-add-3, one bit per clock).
//   - Holds the result in a digit register.
//   - Time-multiplexes the digits onto one shared segment bus plus one-hot digit enables.

---
 rtl/sev_seg_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_sev_seg_scan_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/sev_seg_scan_ctrl.sv
// Multiplexed N-digit seven-segment controller: sequential binary-to-BCD conversion plus free-running digit scan.
// Define SEV_SEG_LZB_EN to blank leading zero digits (digit 0 and overflow dashes are never blanked).
module sev_seg_scan_ctrl #(
  parameter int NUM_WIDTH   = 14,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [NUM_WIDTH-1:0]  number,
  output logic                  busy,
  output logic                  ovf,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int TOT_W = BCD_W + NUM_WIDTH;
  localparam int BIT_W = $clog2(NUM_WIDTH + 1);
  localparam int RD_W  = $clog2(REFRESH_DIV + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [31:0]      MAX_VAL      = 32'(10 ** NUM_DIGITS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(NUM_WIDTH - 1);
  localparam logic [RD_W-1:0]  REFRESH_LAST = RD_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CONV = 1'b1;

  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  logic [0:0]            state_q, state_d;
  logic [NUM_WIDTH-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]      digits_q, digits_d;
  logic                  ovf_q, ovf_d;
  logic [RD_W-1:0]       refresh_q, refresh_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;

  logic [BCD_W-1:0] bcd_adj;
  logic [TOT_W-1:0] shifted;
  logic [3:0]       cur_digit;
  logic             blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1111110;
      4'd1:    decode = 7'b0110000;
      4'd2:    decode = 7'b1101101;
      4'd3:    decode = 7'b1111001;
      4'd4:    decode = 7'b0110011;
      4'd5:    decode = 7'b1011011;
      4'd6:    decode = 7'b1011111;
      4'd7:    decode = 7'b1110000;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1111011;
      default: decode = SEG_DASH;
    endcase
  endfunction

  // Shift-add-3 converter: one input bit per clock, commit on the last step.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    bit_cnt_d  = bit_cnt_q;
    ovf_pend_d = ovf_pend_q;
    digits_d   = digits_q;
    ovf_d      = ovf_q;
    bcd_adj    = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin_q} << 1;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          bin_d      = number;
          bcd_d      = '0;
          bit_cnt_d  = '0;
          ovf_pend_d = 32'(number) > MAX_VAL;
          state_d    = ST_CONV;
        end
      end
      ST_CONV: begin
        {bcd_d, bin_d} = shifted;
        bit_cnt_d      = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_LAST) begin
          state_d  = ST_IDLE;
          digits_d = shifted[TOT_W-1 -: BCD_W];
          ovf_d    = ovf_pend_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scan uses next-state digits so a commit shows up on the same edge as the enable.
  always_comb begin
    refresh_d = refresh_q + 1'b1;
    idx_d     = idx_q;
    if (refresh_q == REFRESH_LAST) begin
      refresh_d = '0;
      idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    an_d        = '0;
    an_d[idx_d] = 1'b1;
    cur_digit   = digits_d[{idx_d, 2'b00} +: 4];
`ifdef SEV_SEG_LZB_EN
    blank = (idx_d != '0) && ((digits_d >> {idx_d, 2'b00}) == '0);
`else
    blank = 1'b0;
`endif
    if (ovf_d)      seg_d = SEG_DASH;
    else if (blank) seg_d = SEG_BLANK;
    else            seg_d = decode(cur_digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      bit_cnt_q  <= '0;
      ovf_pend_q <= 1'b0;
      digits_q   <= '0;
      ovf_q      <= 1'b0;
      refresh_q  <= '0;
      idx_q      <= '0;
      an_q       <= NUM_DIGITS'(1);
      seg_q      <= 7'b1111110;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      bit_cnt_q  <= bit_cnt_d;
      ovf_pend_q <= ovf_pend_d;
      digits_q   <= digits_d;
      ovf_q      <= ovf_d;
      refresh_q  <= refresh_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign busy = (state_q == ST_CONV);
  assign ovf  = ovf_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Table-driven bench for sev_seg_scan_ctrl with a queue of expected display results.
// Expected leading-zero segments follow the SEV_SEG_LZB_EN build setting.
module tb_sev_seg_scan_ctrl;

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011, S5 = 7'b1011011, S7 = 7'b1110000, S9 = 7'b1111011;
  localparam logic [6:0] DSH = 7'b0000001;
`ifdef SEV_SEG_LZB_EN
  localparam logic [6:0] LZ = 7'b0000000;
`else
  localparam logic [6:0] LZ = 7'b1111110;
`endif

  typedef struct {
    logic [13:0]      number;
    logic             ovf;
    logic [3:0][6:0]  seg;
    int               busy_len;
    int               extra_load;
    int               rst_at;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [13:0] number = '0;
  logic        busy, ovf;
  logic [6:0]  seg;
  logic [3:0]  an;

  int   total = 0;
  int   passed = 0;
  int   k = 0;
  vec_t vecs [12];
  vec_t sb [$];

  sev_seg_scan_ctrl #(.NUM_WIDTH(14), .NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .number(number),
    .busy(busy), .ovf(ovf), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  // Edges since the last reset edge; the expected scan position follows from it directly.
  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
  endtask

  function automatic vec_t mk(input logic [13:0] n, input logic o,
                              input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0,
                              input int blen, input int xl, input int ra);
    vec_t v;
    v.number = n; v.ovf = o; v.seg = {s3, s2, s1, s0};
    v.busy_len = blen; v.extra_load = xl; v.rst_at = ra;
    return v;
  endfunction

  // Caller is at a negedge; drives the load, tracks busy, then verifies the display scan.
  task automatic applyStimulus(input vec_t v);
    int   cyc;
    int   ei;
    vec_t e;
    cyc = 0;
    load = 1'b1; number = v.number; sb.push_back(v);
    @(negedge clk);
    load = 1'b0;
    while (busy && cyc < 40) begin
      cyc++;
      if (cyc == v.extra_load) begin load = 1'b1; number = 14'd5678; end
      else load = 1'b0;
      rst = (cyc == v.rst_at);
      @(negedge clk);
    end
    load = 1'b0; rst = 1'b0;
    checkOutput($sformatf("busy_len_%0d", v.number), cyc, v.busy_len);
    e = sb.pop_front();
    checkOutput($sformatf("ovf_%0d", e.number), 32'(ovf), 32'(e.ovf));
    checkOutput($sformatf("busy_low_%0d", e.number), 32'(busy), 32'd0);
    for (int c = 0; c < 16; c++) begin
      ei = (k / 4) % 4;
      checkOutput($sformatf("an_%0d", e.number), 32'(an), 32'(4'b0001 << ei));
      checkOutput($sformatf("seg_%0d_d%0d", e.number, ei), 32'(seg), 32'(e.seg[ei]));
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0]  = mk(14'd1234,  1'b0, S1,  S2,  S3,  S4,  14, 0, 0);
    vecs[1]  = mk(14'd10000, 1'b1, DSH, DSH, DSH, DSH, 14, 0, 0);
    vecs[2]  = mk(14'd42,    1'b0, LZ,  LZ,  S4,  S2,  14, 0, 0);
    vecs[3]  = mk(14'd1234,  1'b0, S1,  S2,  S3,  S4,  14, 3, 0);
    vecs[4]  = mk(14'd1234,  1'b0, S1,  S2,  S3,  S4,  14, 14, 0);
    vecs[5]  = mk(14'd16383, 1'b1, DSH, DSH, DSH, DSH, 14, 0, 0);
    vecs[6]  = mk(14'd9999,  1'b0, LZ,  LZ,  LZ,  S0,  5, 0, 5);
    vecs[7]  = mk(14'd7,     1'b0, LZ,  LZ,  LZ,  S7,  14, 0, 0);
    vecs[8]  = mk(14'd0,     1'b0, LZ,  LZ,  LZ,  S0,  14, 0, 0);
    vecs[9]  = mk(14'd1005,  1'b0, S1,  S0,  S0,  S5,  14, 0, 0);
    vecs[10] = mk(14'd9999,  1'b0, S9,  S9,  S9,  S9,  14, 0, 0);
    vecs[11] = mk(14'd10000, 1'b1, DSH, DSH, DSH, DSH, 14, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ovf",  32'(ovf),  32'd0);
    checkOutput("rst_an",   32'(an),   32'b0001);
    checkOutput("rst_seg",  32'(seg),  32'(S0));
    repeat (4) @(negedge clk);
    checkOutput("scan_step_an", 32'(an), 32'b0010);

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
